// File: rtl/spis_intf_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : spis_intf_gen_if
//  Purpose  : SPI pins plus register read/write port of the SPI slave front end
//  Revision : 1.0  initial release
// ============================================================================
interface spis_intf_gen_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic              reg_wr;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              reg_rd;
    logic [ADDR_W-1:0] reg_rd_addr;
    logic [DATA_W-1:0] reg_rd_data;
    logic              busy;
    logic              cmd_err;
    logic              ovr_err;
    logic              frame_abort;

    modport slave (
        input  ss_n, mosi, reg_rd_data,
        output miso, reg_wr, reg_wr_addr, reg_wr_data, reg_rd, reg_rd_addr,
               busy, cmd_err, ovr_err, frame_abort
    );

    modport master (
        output ss_n, mosi, reg_rd_data,
        input  miso, reg_wr, reg_wr_addr, reg_wr_data, reg_rd, reg_rd_addr,
               busy, cmd_err, ovr_err, frame_abort
    );
endinterface
`default_nettype wire

// File: rtl/spis_intf_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spis_intf_gen
//  Purpose  : parametrised SPI slave; command/address/data deserialiser with
//             burst register access and MISO read-back
//  Revision : 1.0  initial release
// ============================================================================
module spis_intf_gen #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int BLEN_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic           sclk,
    input  logic           rst,
    spis_intf_gen_if.slave bus
);

    localparam int c_bcnt_w = $clog2(DATA_W);
    localparam logic [c_bcnt_w-1:0] c_last     = c_bcnt_w'(DATA_W - 1);
    localparam logic [c_bcnt_w-1:0] c_bcnt_one = c_bcnt_w'(1);
    localparam logic [BLEN_W-1:0]   c_blen_one = BLEN_W'(1);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_cmd  = 3'd1;
    localparam logic [2:0] c_st_wr   = 3'd2;
    localparam logic [2:0] c_st_rd   = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;
    localparam logic [2:0] c_st_err  = 3'd5;

    localparam logic [7:0] c_op_rd  = 8'h00;
    localparam logic [7:0] c_op_wr  = 8'h01;
    localparam logic [7:0] c_op_brd = 8'h20;
    localparam logic [7:0] c_op_bwr = 8'h21;

    logic [2:0]          state_q, state_d;
    logic [c_bcnt_w-1:0] bcnt_q, bcnt_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [BLEN_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic                is_wr_q, is_wr_d;
    logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_pend_q, wr_pend_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_cap_q, rd_cap_d;
    logic                reg_wr_q, reg_wr_d;
    logic                reg_rd_q, reg_rd_d;
    logic [ADDR_W-1:0]   reg_wr_addr_q, reg_wr_addr_d;
    logic [DATA_W-1:0]   reg_wr_data_q, reg_wr_data_d;
    logic [ADDR_W-1:0]   reg_rd_addr_q, reg_rd_addr_d;
    logic                cmd_err_q, cmd_err_d;
    logic                ovr_err_q, ovr_err_d;
    logic                frame_abort_q, frame_abort_d;

    logic                w_wb;
    logic [DATA_W-1:0]   w_word;
    logic [7:0]          w_opcode;
    logic [BLEN_W-1:0]   w_cmd_blen;
    logic [ADDR_W-1:0]   w_cmd_addr;
    logic                w_op_single;
    logic                w_op_burst;
    logic                w_cmd_ok;
    logic [BLEN_W-1:0]   w_count;
    logic [ADDR_W-1:0]   w_addr_step;

    generate
        if (AUTO_INC != 0) begin : g_addr_inc
            assign w_addr_step = ADDR_W'(1);
        end else begin : g_addr_fixed
            assign w_addr_step = '0;
        end
    endgenerate

    assign w_wb        = ~bus.ss_n & (bcnt_q == c_last);
    assign w_word      = {shift_q, bus.mosi};
    assign w_opcode    = w_word[DATA_W-1 -: 8];
    assign w_cmd_blen  = w_word[ADDR_W+BLEN_W-1 : ADDR_W];
    assign w_cmd_addr  = w_word[ADDR_W-1:0];
    assign w_op_single = (w_opcode == c_op_rd) | (w_opcode == c_op_wr);
    assign w_op_burst  = (w_opcode == c_op_brd) | (w_opcode == c_op_bwr);
    assign w_cmd_ok    = w_op_single | (w_op_burst & (w_cmd_blen != '0));
    assign w_count     = w_op_burst ? w_cmd_blen : c_blen_one;

    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        cnt_d         = cnt_q;
        cur_addr_d    = cur_addr_q;
        is_wr_d       = is_wr_q;
        rd_buf_d      = rd_buf_q;
        rd_valid_d    = rd_valid_q;
        wr_pend_d     = 1'b0;
        rd_pend_d     = 1'b0;
        rd_cap_d      = reg_rd_q;
        reg_wr_d      = wr_pend_q;
        reg_rd_d      = rd_pend_q;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_rd_addr_d = reg_rd_addr_q;
        cmd_err_d     = cmd_err_q;
        ovr_err_d     = ovr_err_q;
        frame_abort_d = 1'b0;

        // Read data is valid the cycle after the strobe; park it until the next word boundary.
        if (rd_cap_q) begin
            rd_buf_d   = bus.reg_rd_data;
            rd_valid_d = 1'b1;
        end

        if (bus.ss_n) begin
            frame_abort_d = (bcnt_q != '0);
            state_d       = c_st_idle;
            bcnt_d        = '0;
            shift_d       = '0;
            tx_d          = '0;
            cnt_d         = '0;
            rd_valid_d    = 1'b0;
        end else begin
            bcnt_d  = w_wb ? '0 : bcnt_q + c_bcnt_one;
            shift_d = w_word[DATA_W-2:0];
            tx_d    = {tx_q[DATA_W-2:0], 1'b0};
            case (state_q)
                c_st_idle: begin
                    state_d   = c_st_cmd;
                    cmd_err_d = 1'b0;
                    ovr_err_d = 1'b0;
                end
                c_st_cmd: begin
                    if (w_wb) begin
                        tx_d       = '0;
                        rd_valid_d = 1'b0;
                        if (!w_cmd_ok) begin
                            cmd_err_d = 1'b1;
                            state_d   = c_st_err;
                        end else if (w_opcode[0]) begin
                            is_wr_d    = 1'b1;
                            cnt_d      = w_count;
                            cur_addr_d = w_cmd_addr;
                            state_d    = c_st_wr;
                        end else begin
                            is_wr_d       = 1'b0;
                            rd_pend_d     = 1'b1;
                            reg_rd_addr_d = w_cmd_addr;
                            cnt_d         = w_count - c_blen_one;
                            cur_addr_d    = w_cmd_addr + w_addr_step;
                            state_d       = (w_count == c_blen_one) ? c_st_done : c_st_rd;
                        end
                    end
                end
                c_st_wr: begin
                    if (w_wb) begin
                        wr_pend_d     = 1'b1;
                        reg_wr_data_d = w_word;
                        reg_wr_addr_d = cur_addr_q;
                        cur_addr_d    = cur_addr_q + w_addr_step;
                        cnt_d         = cnt_q - c_blen_one;
                        if (cnt_q == c_blen_one) begin
                            state_d = c_st_done;
                        end
                    end
                end
                c_st_rd: begin
                    if (w_wb) begin
                        rd_pend_d     = 1'b1;
                        reg_rd_addr_d = cur_addr_q;
                        cur_addr_d    = cur_addr_q + w_addr_step;
                        cnt_d         = cnt_q - c_blen_one;
                        if (cnt_q == c_blen_one) begin
                            state_d = c_st_done;
                        end
                        tx_d       = rd_valid_q ? rd_buf_q : '0;
                        rd_valid_d = 1'b0;
                    end
                end
                c_st_done: begin
                    if (w_wb) begin
                        if (is_wr_q) begin
                            ovr_err_d = 1'b1;
                        end else begin
                            // Drains the final read word, then zeros once nothing is left.
                            tx_d       = rd_valid_q ? rd_buf_q : '0;
                            rd_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    tx_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q       <= c_st_idle;
            bcnt_q        <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            cnt_q         <= '0;
            cur_addr_q    <= '0;
            is_wr_q       <= 1'b0;
            rd_buf_q      <= '0;
            rd_valid_q    <= 1'b0;
            wr_pend_q     <= 1'b0;
            rd_pend_q     <= 1'b0;
            rd_cap_q      <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_rd_q      <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            reg_rd_addr_q <= '0;
            cmd_err_q     <= 1'b0;
            ovr_err_q     <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            cnt_q         <= cnt_d;
            cur_addr_q    <= cur_addr_d;
            is_wr_q       <= is_wr_d;
            rd_buf_q      <= rd_buf_d;
            rd_valid_q    <= rd_valid_d;
            wr_pend_q     <= wr_pend_d;
            rd_pend_q     <= rd_pend_d;
            rd_cap_q      <= rd_cap_d;
            reg_wr_q      <= reg_wr_d;
            reg_rd_q      <= reg_rd_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_rd_addr_q <= reg_rd_addr_d;
            cmd_err_q     <= cmd_err_d;
            ovr_err_q     <= ovr_err_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign bus.miso        = tx_q[DATA_W-1];
    assign bus.reg_wr      = reg_wr_q;
    assign bus.reg_wr_addr = reg_wr_addr_q;
    assign bus.reg_wr_data = reg_wr_data_q;
    assign bus.reg_rd      = reg_rd_q;
    assign bus.reg_rd_addr = reg_rd_addr_q;
    assign bus.busy        = (state_q != c_st_idle);
    assign bus.cmd_err     = cmd_err_q;
    assign bus.ovr_err     = ovr_err_q;
    assign bus.frame_abort = frame_abort_q;

endmodule
`default_nettype wire

// File: doc/spis_intf_gen.md
Name: spis_intf_gen

Overview:
- Parametrised SPI slave front end; successor to the fixed 32-bit SPI slave interface.
- Deserialises MOSI frames into command, address and data words, and drives a single-cycle register read/write port toward the SPI register block.
- Serialises read data onto MISO.
- Adds over the previous generation: generic word/address/burst widths, address auto-increment, burst-length checking, sticky error flags, and a mid-word abort indication.

Parameters:
- DATA_W, 32, SPI word width in bits; 16..64, multiple of 8; DATA_W >= 8+BLEN_W+ADDR_W.
- ADDR_W, 16, register address width.
- BLEN_W, 8, burst length field width.
- AUTO_INC, 1, 1 = address increments by 1 per burst word; 0 = fixed address (FIFO-style target).

Ports:
- sclk  in  1  SPI clock; all logic on posedge sclk only.
- rst  in  1  synchronous, active-high reset.
- ss_n  in  1  slave select, active low, sampled at posedge sclk.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- reg_wr  out  1  one-cycle write strobe.
- reg_wr_addr  out  ADDR_W  write address.
- reg_wr_data  out  DATA_W  write data.
- reg_rd  out  1  one-cycle read strobe.
- reg_rd_addr  out  ADDR_W  read address.
- reg_rd_data  in  DATA_W  read data; valid the cycle after reg_rd.
- busy  out  1  frame in progress (state != IDLE).
- cmd_err  out  1  sticky: illegal opcode or zero burst length.
- ovr_err  out  1  sticky: more data words received than the burst length.
- frame_abort  out  1  one-cycle pulse: ss_n rose with a partial word received.

Behaviour:
- Reset and interface conventions:
  - Clock and reset: single clock sclk; reset is synchronous and active-high, port rst.
  - Reset values: miso, reg_wr, reg_rd, busy, cmd_err, ovr_err, frame_abort = 0; reg_wr_addr, reg_rd_addr, reg_wr_data = 0; state IDLE.
  - ss_n high at a posedge: bit counter, shift registers and state return to IDLE/0 on that edge, same as rst. cmd_err and ovr_err are exceptions: they hold until rst, or until the first edge with ss_n low of the next frame, which clears them.
- Framing:
  - Bit counter bcnt counts 0..DATA_W-1 while ss_n is low, then wraps.
  - Word boundary (wb) = edge on which bcnt == DATA_W-1; the received word is {shift, mosi}.
  - Word 0 of every frame is the command.
  - Command fields: opcode = [DATA_W-1 -: 8], blen = [ADDR_W+BLEN_W-1 : ADDR_W], addr = [ADDR_W-1:0].
- Opcodes:
  - 0x00 single read (count 1).
  - 0x01 single write (count 1).
  - 0x20 burst read (count blen).
  - 0x21 burst write (count blen).
  - Other opcode, or blen == 0 on a burst opcode -> cmd_err = 1, state ERR. ERR ignores all traffic, miso = 0, until ss_n high.
- States: IDLE -> CMD on first edge with ss_n low. CMD at wb -> WR, RD or ERR. WR/RD -> DONE when remaining count reaches 0. DONE/ERR -> IDLE on ss_n high.
- Write path:
  - Each wb in WR: reg_wr pulses on the next edge (one cycle after wb), with reg_wr_data = the word and reg_wr_addr = addr + i.
  - i = burst index from 0; with AUTO_INC = 0, reg_wr_addr stays at addr.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - Remaining count decrements at each wb.
  - A wb received in DONE after a write burst -> ovr_err = 1, no reg_wr.
- Read path:
  - Word 1 is a turnaround word; miso = 0 during it.
  - reg_rd pulses one cycle after the command wb, reg_rd_addr = addr. reg_rd_data is captured one cycle later.
  - The captured word loads into the TX shift register at the next wb and shifts out MSB first during the following word.
  - Read data k therefore appears during frame word k+2.
  - Further reg_rd pulses fire one cycle after each subsequent wb, at addr + k, until count reads are issued.
  - MOSI content during reads is ignored.
  - After the last read word, miso = 0.
- MISO timing: miso = TX MSB and changes only just after posedge. The master samples frame bit n on posedge n+1, so the bit launched at wb is sampled on the first edge of the next word.
- Abort: ss_n high while bcnt != 0 -> frame_abort pulses on that edge. The partial word is discarded, with no reg_wr/reg_rd from it.
- Simultaneous events: a wb on the same edge ss_n rises is not a wb; the frame aborts.
- Reset mid-operation: same as ss_n high; any pending reg_rd/reg_wr strobe is suppressed.

Test Plan:
- Single write: cmd 0x01_00_0040, data 0xDEADBEEF -> one reg_wr one cycle after 2nd wb, addr 0x0040, data 0xDEADBEEF; no reg_rd.
- Burst write: blen = 3, addr 0xFFFE, AUTO_INC = 1, 3 data words -> reg_wr at 0xFFFE, 0xFFFF, 0x0000 (wrap); a 4th word sets ovr_err = 1 and issues no strobe.
- Burst read: blen = 2, addr 0x1000, reg_rd_data model returns addr+0xA5A50000 -> reg_rd at 0x1000 and 0x1001; miso shows 0 in word 1, 0xA5A51000 in word 2, 0xA5A51001 in word 3.
- Error opcode: cmd 0x7F_..., or 0x20 with blen = 0 -> cmd_err = 1, no strobes, miso = 0; cmd_err clears on the next frame's first ss_n-low edge.
- Abort: ss_n rises at bit 17 of a write data word -> frame_abort pulse, no reg_wr, busy = 0 on the next edge.
- Parameter sweep: DATA_W = 48, ADDR_W = 24, AUTO_INC = 0, 4-word burst write -> all 4 reg_wr at the same address; rst asserted mid-burst drops all strobes and clears both error flags.
